// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Issue register (S1) drives the ALU; response register (S2) captures the result.
module alu_share_arbiter #(
    parameter int             WIDTH  = 32,
    parameter int             OPW    = 4,
    parameter logic [OPW-1:0] XXX_OP = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             busy
);

    logic             s1_valid, s1_id, s1_err;
    logic [OPW-1:0]   s1_op;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic             s2_valid, s2_id, s2_err;
    logic [WIDTH-1:0] s2_data;
    logic             last_grant;

    logic             s2_free, s1_adv, accept_en;
    logic             take0, take1, accept;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    always_comb begin
        s2_free   = !s2_valid || resp_ready;
        s1_adv    = s1_valid && s2_free;
        accept_en = !s1_valid || s1_adv;
        // Each ready looks only at the other port's valid, so no valid->own-ready path exists.
        r0_ready  = accept_en && (!r1_valid || last_grant);
        r1_ready  = accept_en && (!r0_valid || !last_grant);
        take0     = r0_valid && r0_ready;
        take1     = r1_valid && r1_ready;
        accept    = take0 || take1;
        sel_op    = take1 ? r1_op : r0_op;
        sel_a     = take1 ? r1_a  : r0_a;
        sel_b     = take1 ? r1_b  : r0_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_id      <= 1'b0;
            s1_err     <= 1'b0;
            s1_op      <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_id      <= take1;
            s1_err     <= (sel_op == XXX_OP);
            s1_op      <= sel_op;
            s1_a       <= sel_a;
            s1_b       <= sel_b;
            last_grant <= take1;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_err   <= 1'b0;
            s2_data  <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_id    <= s1_id;
            s2_err   <= s1_err;
            s2_data  <= s1_err ? '0 : alu_result;
        end else if (resp_ready && s2_valid) begin
            s2_valid <= 1'b0;
        end
    end

    always_comb begin
        alu_op     = s1_op;
        alu_a      = s1_a;
        alu_b      = s1_b;
        resp_valid = s2_valid;
        resp_id    = s2_id;
        resp_err   = s2_err;
        resp_data  = s2_data;
        busy       = s1_valid || s2_valid;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle combinational ALU between two requesters: port 0 is the execute stage, port 1 is the branch/address-generation helper.
- Arbitration is round-robin. The block registers the winning operation into an issue stage that drives the ALU, then captures the result into a response stage. The response stage carries the requester ID and a valid/ready handshake.
- Sits between the decode/execute control, which supplies 4-bit ALUop codes from the ALU decoder, and the ALU.

Parameters:
- WIDTH, 32, operand and result width.
- OPW, 4, ALUop width; must match the ALUop encoding.
- XXX_OP, 4'b1111, ALUop value meaning "undefined op"; a request carrying it is flagged as an error.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 has an op
- r0_ready  out  1  requester 0 op accepted this cycle when high together with r0_valid
- r0_op  in  OPW  requester 0 ALUop
- r0_a  in  WIDTH  requester 0 operand A
- r0_b  in  WIDTH  requester 0 operand B
- r1_valid, r1_ready, r1_op, r1_a, r1_b  same as r0, for requester 1
- alu_op  out  OPW  to ALU, from issue register
- alu_a  out  WIDTH  to ALU, from issue register
- alu_b  out  WIDTH  to ALU, from issue register
- alu_result  in  WIDTH  combinational ALU output
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer takes the response
- resp_id  out  1  requester that issued the op
- resp_data  out  WIDTH  captured ALU result
- resp_err  out  1  op was XXX_OP; resp_data is 0
- busy  out  1  issue or response stage occupied

Behaviour:
- Reset (async assert, sync-release assumed external): clear s1_valid, s2_valid and last_grant (=1, so port 0 wins first). alu_op/alu_a/alu_b/resp_data=0, resp_id=0, resp_err=0, resp_valid=0, busy=0.
- Stages: S1 = issue register (op, a, b, id, err) feeding the alu_* outputs; S2 = response register.
- Handshake enables:
  - s2_free = !s2_valid | resp_ready.
  - s1_adv = s1_valid & s2_free.
  - accept_en = !s1_valid | s1_adv.
- Ready paths: r0_ready and r1_ready depend combinationally on resp_ready through accept_en. There is no combinational path from any rX_valid to its own rX_ready.
- Grant, evaluated when accept_en=1:
  - Only one valid: grant it.
  - Both valid: grant the port that is not last_grant.
  - Neither valid: no grant; last_grant holds.
- rX_ready = accept_en & grant==X. The loser's ready is low; it must hold valid and operands stable.
- On accept: S1 <= {op, a, b, id=X, err=(op==XXX_OP)}, s1_valid <= 1, last_grant <= X.
- On s1_adv:
  - S2 <= {id, err, data = err ? 0 : alu_result}, s2_valid <= 1.
  - If no new accept in the same cycle, s1_valid <= 0.
- On resp_ready & s2_valid with no s1_adv: s2_valid <= 0.
- Latency: op accepted at edge N → resp_valid high in cycle after edge N+1. This is 2 edges.
- Throughput: 1 op/cycle with resp_ready held high.
- Backpressure:
  - resp_ready low with S2 full → S2 holds, S1 holds, both readys low. Contents stay stable until drained.
  - After one cycle of resp_ready high, the pipeline resumes without loss or duplication.
- Ordering: responses appear in acceptance order. Ops issued from the same port return in program order.
- alu_* outputs hold the last issued op while S1 is empty. They are don't-care but stable; no toggling when idle.
- busy = s1_valid | s2_valid.
- Reset mid-operation: in-flight S1/S2 contents are dropped; no response is produced for them.

Test Plan:
- Single op: r0 op=ADD, a=5, b=7, resp_ready=1 → r0_ready high that cycle; 2 edges later resp_valid=1, resp_id=0, resp_data=12, resp_err=0.
- Contention: r0 and r1 both valid continuously for 6 cycles, resp_ready=1 → grants alternate 0,1,0,1,0,1; resp_id follows the same pattern with correct data.
- Backpressure: 3 back-to-back r1 ops (SUB 9-4, XOR F0^0F, SLL 1<<4), resp_ready low for 4 cycles after the first response → first response held stable as 5, r1_ready low while full; after release, responses 5, FF, 10 in order, with no loss and no duplicates.
- Error op: r0 op=4'b1111, a=3, b=3 → resp_err=1, resp_data=0, resp_id=0; the next valid op is unaffected.
- Reset mid-flight: assert rst_n low while S1 and S2 are full → all outputs zero immediately; after release, r0 wins the first grant and no stale response appears.
- Idle stability: no requests for 10 cycles → alu_* unchanged, busy=0, last_grant unchanged (verified by the next simultaneous request going to the expected port).
